// File: rtl/plane_pixel_shifter.sv
// Bitplane word buffer plus parallel-load/serial-out shifters feeding a layer colour mux.

// Small generic FIFO used as the word buffer ahead of the plane shifters.
// Latency: an entry pushed on one edge is at the pop side from the next cycle.
// Backpressure: push_rdy is low while full, derived from the registered count only.
module ppx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         RESETn,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         pop_vld,
    output logic [W-1:0] pop_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign push_rdy = (count < FULL);
    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[rd_ptr];
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop && pop_vld;

    always_ff @(posedge clk) begin
        if (!RESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// Plane shifters: one serial pixel bit per bitplane, words loaded from a 2-deep buffer.
// Latency: a buffered word appears on pix_out the cycle after the wrapping pixel strobe.
// Backpressure: in_ready drops when two words are buffered; an empty buffer at wrap fills transparent.
module plane_pixel_shifter #(
    parameter int PLANES   = 3,
    parameter int WORD_W   = 8,
    parameter bit FILL_BIT = 1'b1,
    parameter bit CEN_EDGE = 1'b1
) (
    input  logic                     clk,
    input  logic                     RESETn,
    input  logic                     pix_cen,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PLANES*WORD_W-1:0] in_data,
    input  logic                     in_flip,
    input  logic                     in_blank,
    output logic [PLANES-1:0]        pix_out,
    output logic                     out_valid,
    output logic                     word_start,
    output logic                     underrun
);
    localparam int CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int DW = PLANES * WORD_W;
    localparam int EW = DW + 2;
    localparam logic [CW-1:0] LAST_PIX = CW'(WORD_W - 1);

    logic                               last_cen;
    logic                               strobe;
    logic                               wrap;
    logic                               head_vld;
    logic                               head_flip;
    logic                               head_blank;
    logic [EW-1:0]                      head;
    logic [DW-1:0]                      head_data;
    logic [CW-1:0]                      pix_cnt;
    logic [PLANES-1:0][WORD_W-1:0]      shreg;
    logic [PLANES-1:0][WORD_W-1:0]      load_word;

    ppx_fifo #(.W(EW), .DEPTH(2)) u_word_buf (
        .clk      (clk),
        .RESETn   (RESETn),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat ({in_blank, in_flip, in_data}),
        .pop      (wrap),
        .pop_vld  (head_vld),
        .pop_dat  (head)
    );

    assign {head_blank, head_flip, head_data} = head;
    assign strobe = CEN_EDGE ? (pix_cen & ~last_cen) : pix_cen;
    assign wrap   = strobe && (pix_cnt == LAST_PIX);

    // Flip is a bit reversal at load time, so it never leaks into adjacent words.
    always_comb begin
        load_word = '0;
        for (int p = 0; p < PLANES; p++) begin
            for (int b = 0; b < WORD_W; b++) begin
                if (head_blank)
                    load_word[p][b] = FILL_BIT;
                else if (head_flip)
                    load_word[p][b] = head_data[p*WORD_W + WORD_W - 1 - b];
                else
                    load_word[p][b] = head_data[p*WORD_W + b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RESETn) begin
            last_cen   <= 1'b1;
            pix_cnt    <= LAST_PIX;
            shreg      <= {DW{FILL_BIT}};
            out_valid  <= 1'b0;
            word_start <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            last_cen   <= pix_cen;
            word_start <= 1'b0;
            underrun   <= 1'b0;
            if (wrap) begin
                pix_cnt    <= '0;
                out_valid  <= head_vld;
                word_start <= head_vld;
                underrun   <= !head_vld;
                shreg      <= head_vld ? load_word : {DW{FILL_BIT}};
            end else if (strobe) begin
                pix_cnt <= pix_cnt + 1'b1;
                for (int p = 0; p < PLANES; p++)
                    shreg[p] <= {shreg[p][WORD_W-2:0], FILL_BIT};
            end
        end
    end

    always_comb begin
        pix_out = '0;
        for (int p = 0; p < PLANES; p++)
            pix_out[p] = shreg[p][WORD_W-1];
    end
endmodule

// File: tb/tb_plane_pixel_shifter.sv
// Directed bench: edge-strobe instance is the main target, level-strobe instance shares all inputs.
module tb_plane_pixel_shifter;
    logic        clk = 1'b0;
    logic        RESETn = 1'b0;
    logic        pix_cen = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_flip = 1'b0;
    logic        in_blank = 1'b0;
    logic [23:0] in_data = '0;

    logic       in_ready, out_valid, word_start, underrun;
    logic [2:0] pix_out;
    logic       in_ready_l, out_valid_l, word_start_l, underrun_l;
    logic [2:0] pix_out_l;

    int n_cmp = 0;
    int n_err = 0;

    logic [23:0] w;
    logic [23:0] ws [3];
    int          n_ur;

    always #5 clk = ~clk;

    plane_pixel_shifter #(.PLANES(3), .WORD_W(8), .FILL_BIT(1'b1), .CEN_EDGE(1'b1)) u_edge (
        .clk(clk), .RESETn(RESETn), .pix_cen(pix_cen), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_flip(in_flip), .in_blank(in_blank), .pix_out(pix_out),
        .out_valid(out_valid), .word_start(word_start), .underrun(underrun)
    );

    plane_pixel_shifter #(.PLANES(3), .WORD_W(8), .FILL_BIT(1'b1), .CEN_EDGE(1'b0)) u_level (
        .clk(clk), .RESETn(RESETn), .pix_cen(pix_cen), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_data(in_data), .in_flip(in_flip), .in_blank(in_blank), .pix_out(pix_out_l),
        .out_valid(out_valid_l), .word_start(word_start_l), .underrun(underrun_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Pixel k of a word as the colour mux should see it: MSB first, or LSB first when flipped.
    function automatic logic [2:0] pix(input logic [23:0] wd, input bit flip, input int k);
        logic [2:0] r;
        for (int p = 0; p < 3; p++)
            r[p] = flip ? wd[p*8 + k] : wd[p*8 + 7 - k];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hi();
        pix_cen = 1'b1;
        tick();
    endtask

    task automatic lo();
        pix_cen = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_pix", pix_out, 3'b111);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_word_start", word_start, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        RESETn = 1'b1;
        tick();

        // Idle: underrun on strobes 0 and 8, transparent pixels throughout
        n_ur = 0;
        for (int k = 0; k < 16; k++) begin
            hi();
            chk("idle_underrun", underrun, (k % 8 == 0) ? 1'b1 : 1'b0);
            chk("idle_pix", pix_out, 3'b111);
            chk("idle_out_valid", out_valid, 1'b0);
            if (underrun) n_ur++;
            lo();
            chk("idle_underrun_pulse", underrun, 1'b0);
        end
        chk("idle_underrun_count", n_ur, 2);

        // Plain word {FF,0F,A5}
        w = 24'hFF0FA5;
        in_data = w; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("w2_in_ready", in_ready, 1'b1);
        for (int k = 0; k < 8; k++) begin
            hi();
            chk("w2_pix", pix_out, pix(w, 1'b0, k));
            chk("w2_word_start", word_start, (k == 0) ? 1'b1 : 1'b0);
            chk("w2_out_valid", out_valid, 1'b1);
            lo();
            chk("w2_word_start_pulse", word_start, 1'b0);
        end
        chk("w2_first_p0_hand", pix(w, 1'b0, 0), 3'b101);

        // Flipped word, with a blank word pushed on the same edge the flipped one pops
        w = {8'h00, 8'h80, 8'h01};
        in_data = w; in_flip = 1'b1; in_valid = 1'b1;
        tick();
        in_data = 24'h123456; in_flip = 1'b0; in_blank = 1'b1;
        for (int k = 0; k < 8; k++) begin
            hi();
            if (k == 0) begin
                in_valid = 1'b0; in_blank = 1'b0;
                chk("flip_in_ready", in_ready, 1'b1);
                chk("flip_first_hand", pix_out, 3'b001);
            end
            chk("flip_pix", pix_out, pix(w, 1'b1, k));
            chk("flip_out_valid", out_valid, 1'b1);
            lo();
        end
        for (int k = 0; k < 8; k++) begin
            hi();
            chk("blank_pix", pix_out, 3'b111);
            chk("blank_out_valid", out_valid, 1'b1);
            chk("blank_underrun", underrun, 1'b0);
            chk("blank_word_start", word_start, (k == 0) ? 1'b1 : 1'b0);
            lo();
        end
        hi();
        chk("post_blank_underrun", underrun, 1'b1);
        chk("post_blank_out_valid", out_valid, 1'b0);
        chk("post_blank_word_start", word_start, 1'b0);
        lo();
        for (int k = 0; k < 7; k++) begin
            hi(); lo();
        end

        // Three words offered back to back before any strobe
        ws[0] = 24'h112233; ws[1] = 24'h4455CC; ws[2] = 24'hA55AC3;
        in_data = ws[0]; in_valid = 1'b1;
        tick();
        chk("fill1_in_ready", in_ready, 1'b1);
        in_data = ws[1];
        tick();
        chk("fill2_in_ready", in_ready, 1'b0);
        in_data = ws[2];
        tick();
        chk("full_hold_in_ready", in_ready, 1'b0);
        hi();
        chk("pop_in_ready", in_ready, 1'b1);
        chk("w4a_pix", pix_out, pix(ws[0], 1'b0, 0));
        chk("w4a_word_start", word_start, 1'b1);
        lo();
        in_valid = 1'b0;
        chk("refill_in_ready", in_ready, 1'b0);
        for (int k = 1; k < 8; k++) begin
            hi();
            chk("w4a_pix", pix_out, pix(ws[0], 1'b0, k));
            lo();
        end
        for (int i = 1; i < 3; i++) begin
            for (int k = 0; k < 8; k++) begin
                hi();
                chk("w4_order_pix", pix_out, pix(ws[i], 1'b0, k));
                if (k == 0) chk("w4_word_start", word_start, 1'b1);
                lo();
            end
        end

        // pix_cen held high 5 clocks: edge mode shifts once, level mode five times
        w = {8'h00, 8'h0F, 8'hF0};
        in_data = w; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        pix_cen = 1'b1;
        tick();
        chk("hold_edge_first", pix_out, 3'b001);
        chk("hold_level_first", pix_out_l, 3'b001);
        tick(); tick(); tick(); tick();
        chk("hold_edge_pix", pix_out, 3'b001);
        chk("hold_level_pix", pix_out_l, 3'b010);
        chk("hold_edge_word_start", word_start, 1'b0);
        pix_cen = 1'b0;
        tick();

        // Reset at pixel 3 with one word buffered
        for (int k = 0; k < 3; k++) begin
            hi(); lo();
        end
        chk("pre_rst_pix3", pix_out, 3'b001);
        in_data = 24'h000000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        RESETn = 1'b0;
        tick();
        chk("midrst_pix", pix_out, 3'b111);
        chk("midrst_level_pix", pix_out_l, 3'b111);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        RESETn = 1'b1;
        tick();
        hi();
        chk("midrst_underrun", underrun, 1'b1);
        chk("midrst_word_start", word_start, 1'b0);
        chk("midrst_lost_pix", pix_out, 3'b111);
        chk("midrst_level_underrun", underrun_l, 1'b1);
        lo();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
